mem_port_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters: the instruction-fetch path (PC address) and the load/store path (ALU address, STUR data).
- Sits between the control unit / datapath and the RAM. It owns the RAM strobes (chip select, read, write) and the RAM address and write-data buses.
- Sequences each access as a multi-cycle transaction with programmable wait states, so the control unit stalls on a done handshake instead of hard-coding state counts.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_wait_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// Optional build macro: MEM_PORT_ARBITER_ALIGN_CHECK_EN (see mem_port_arbiter.sv).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_t;

  localparam int WAIT_W     = 4;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 64;

  // Two-way round robin: on a tie the requester not served last wins.
  function automatic req_t pick_winner(input logic if_req, input logic ls_req,
                                       input req_t last);
    if (if_req && ls_req) begin
      return (last == REQ_IF) ? REQ_LS : REQ_IF;
    end else if (ls_req) begin
      return REQ_LS;
    end else begin
      return REQ_IF;
    end
  endfunction

endpackage

// File: rtl/mem_port_wait_ctr.sv
// Loadable down-counter that times the ACCESS phase; zero marks the last
// ACCESS cycle.
module mem_port_wait_ctr
  import mem_port_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec_en,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data RAM between instruction fetch and load/store.
// Define MEM_PORT_ARBITER_ALIGN_CHECK_EN to reject misaligned LS accesses via ls_err.
//
// Handshake: a requester holds req high until its done pulse; gnt is high from
// the cycle after the grant edge through the DONE cycle; done is a one-cycle
// pulse and the matching rdata is valid in that cycle and held until the next
// capture for the same requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  output logic              ls_err,
`endif
  output logic              RCS,
  output logic              RR,
  output logic              WRR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [WAIT_W-1:0] WS_INIT = WAIT_W'(WAIT_STATES);

  state_t state_q, state_d;
  req_t   winner_q, last_q, win;
  logic   we_q;
  logic   grant;
  logic   ctr_zero;
  logic   last_access;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  logic   misalign;
  logic   err_q;
`endif

  // State register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant decision
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    win     = pick_winner(if_req, ls_req, last_q);
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    misalign = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
          if ((win == REQ_LS) && (ls_addr[2:0] != 3'b000)) begin
            misalign = 1'b1;
            state_d  = DONE;
          end
`endif
        end
      end
      ACCESS: begin
        if (ctr_zero) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign last_access = (state_q == ACCESS) && ctr_zero;

  mem_port_wait_ctr u_wait_ctr (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .load     (grant),
    .load_val (WS_INIT),
    .dec_en   (state_q == ACCESS),
    .zero     (ctr_zero)
  );

  // Transaction latches, read-data capture and round-robin pointer
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      winner_q  <= REQ_IF;
      last_q    <= REQ_IF;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if (grant) begin
        winner_q <= win;
        if (win == REQ_LS) begin
          mem_addr  <= ls_addr;
          mem_wdata <= ls_wdata;
          we_q      <= ls_we;
        end else begin
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          we_q      <= 1'b0;
        end
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
        err_q <= misalign;
`endif
      end
      if (last_access) begin
        if (winner_q == REQ_IF) begin
          if_rdata <= mem_rdata;
        end else if (!we_q) begin
          ls_rdata <= mem_rdata;
        end
      end
      if (state_q == DONE) begin
        last_q <= winner_q;
      end
    end
  end

  // Strobes decode straight from the state flop so reset drops them at once.
  assign busy    = (state_q != IDLE);
  assign RCS     = (state_q == ACCESS);
  assign RR      = RCS && !we_q;
  assign WRR     = RCS && we_q;
  assign if_gnt  = busy && (winner_q == REQ_IF);
  assign ls_gnt  = busy && (winner_q == REQ_LS);
  assign if_done = (state_q == DONE) && (winner_q == REQ_IF);
  assign ls_done = (state_q == DONE) && (winner_q == REQ_LS);
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  assign ls_err  = ls_done && err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with WAIT_STATES=1.
// Honors MEM_PORT_ARBITER_ALIGN_CHECK_EN to exercise ls_err.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;

  logic              CLK = 1'b0;
  logic              Reset_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req = 1'b0;
  logic              ls_we = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0;
  logic              ls_gnt, ls_done;
  logic [DATA_W-1:0] ls_rdata;
  logic              RCS, RR, WRR, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  logic              ls_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram [256];

  // Per-cycle trace, bit c = value seen in cycle c after the request edge
  logic [12:1] v_rcs, v_rr, v_wrr, v_ig, v_lg, v_id, v_ld, v_busy, v_err;

  // Clock and reset
  always #5 CLK = ~CLK;

  mem_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_STATES (1)
  ) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    .ls_err    (ls_err),
`endif
    .RCS       (RCS),
    .RR        (RR),
    .WRR       (WRR),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Behavioural RAM
  assign mem_rdata = (RCS && RR) ? ram[mem_addr[7:0]] : '0;
  always @(posedge CLK) begin
    if (WRR) ram[mem_addr[7:0]] <= mem_wdata;
  end

  // Driver tasks
  task automatic clear_trace;
    v_rcs = '0; v_rr = '0; v_wrr = '0; v_ig = '0; v_lg = '0;
    v_id = '0; v_ld = '0; v_busy = '0; v_err = '0;
  endtask

  task automatic sample_cycle(input int c);
    @(negedge CLK);
    v_rcs[c] = RCS;   v_rr[c] = RR;     v_wrr[c] = WRR;
    v_ig[c] = if_gnt; v_lg[c] = ls_gnt; v_id[c] = if_done;
    v_ld[c] = ls_done; v_busy[c] = busy;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    v_err[c] = ls_err;
`endif
  endtask

  task automatic apply_reset;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    Reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({RCS, RR, WRR, busy, if_gnt, ls_gnt, if_done, ls_done} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {RCS, RR, WRR, busy, if_gnt, ls_gnt, if_done, ls_done});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== 64'h0 || ls_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got if=%h ls=%h want 0", if_rdata, ls_rdata);
    end
    Reset_n = 1'b1;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_fetch;
    logic [ADDR_W-1:0] a1;
    clear_trace();
    if_addr = 16'h0008;
    if_req  = 1'b1;
    a1 = '0;
    for (int c = 1; c <= 5; c++) begin
      sample_cycle(c);
      if (c == 1) a1 = mem_addr;
      if (c == 3) if_req = 1'b0;
    end
    checks++;
    if (v_rcs !== 12'h003 || v_rr !== 12'h003 || v_wrr !== 12'h000) begin
      errors++;
      $display("FAIL fetch_strobes: got rcs=%h rr=%h wrr=%h want 003 003 000", v_rcs, v_rr, v_wrr);
    end
    checks++;
    if (v_id !== 12'h004 || v_ig !== 12'h007 || v_lg !== 12'h000) begin
      errors++;
      $display("FAIL fetch_handshake: got done=%h gnt=%h lsgnt=%h want 004 007 000", v_id, v_ig, v_lg);
    end
    checks++;
    if (if_rdata !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL fetch_rdata: got %h want 00000000deadbeef", if_rdata);
    end
    checks++;
    if (a1 !== 16'h0008) begin
      errors++;
      $display("FAIL fetch_addr: got %h want 0008", a1);
    end
  endtask

  task automatic test_store;
    logic [DATA_W-1:0] wd;
    clear_trace();
    ls_we = 1'b1; ls_addr = 16'h0010; ls_wdata = 64'h1234;
    ls_req = 1'b1;
    wd = '0;
    for (int c = 1; c <= 5; c++) begin
      sample_cycle(c);
      if (c == 2) wd = mem_wdata;
      if (c == 3) begin ls_req = 1'b0; ls_we = 1'b0; end
    end
    checks++;
    if (v_wrr !== 12'h003 || v_rr !== 12'h000) begin
      errors++;
      $display("FAIL store_strobes: got wrr=%h rr=%h want 003 000", v_wrr, v_rr);
    end
    checks++;
    if (v_ld !== 12'h004 || v_lg !== 12'h007) begin
      errors++;
      $display("FAIL store_handshake: got done=%h gnt=%h want 004 007", v_ld, v_lg);
    end
    checks++;
    if (wd !== 64'h1234 || ram[8'h10] !== 64'h1234) begin
      errors++;
      $display("FAIL store_data: got bus=%h ram=%h want 1234", wd, ram[8'h10]);
    end
    checks++;
    if (ls_rdata !== 64'h0) begin
      errors++;
      $display("FAIL store_rdata: got %h want 0", ls_rdata);
    end
  endtask

  task automatic test_tie;
    apply_reset();
    clear_trace();
    if_addr = 16'h0008; ls_addr = 16'h0020; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      sample_cycle(c);
      if (c == 3) ls_req = 1'b0;
      if (c == 7) ls_req = 1'b1;
      if (c == 11) begin ls_req = 1'b0; if_req = 1'b0; end
    end
    checks++;
    if (v_lg !== 12'h707 || v_ig !== 12'h070) begin
      errors++;
      $display("FAIL tie_grants: got ls=%h if=%h want 707 070", v_lg, v_ig);
    end
    checks++;
    if (v_ld !== 12'h404 || v_id !== 12'h040) begin
      errors++;
      $display("FAIL tie_done: got ls=%h if=%h want 404 040", v_ld, v_id);
    end
    checks++;
    if (v_busy !== 12'h777 || v_rcs !== 12'h333) begin
      errors++;
      $display("FAIL tie_bubble: got busy=%h rcs=%h want 777 333", v_busy, v_rcs);
    end
    checks++;
    if (ls_rdata !== 64'hCAFE || if_rdata !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL tie_rdata: got ls=%h if=%h want cafe deadbeef", ls_rdata, if_rdata);
    end
  endtask

  task automatic test_drop;
    clear_trace();
    ls_addr = 16'h0028; ls_we = 1'b0; ls_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      sample_cycle(c);
      if (c == 2) ls_req = 1'b0;
    end
    checks++;
    if (v_ld !== 12'h004 || v_lg !== 12'h007 || v_rcs !== 12'h003) begin
      errors++;
      $display("FAIL drop_txn: got done=%h gnt=%h rcs=%h want 004 007 003", v_ld, v_lg, v_rcs);
    end
    checks++;
    if (ls_rdata !== 64'h5555) begin
      errors++;
      $display("FAIL drop_rdata: got %h want 5555", ls_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic w1;
    clear_trace();
    ls_we = 1'b1; ls_addr = 16'h0030; ls_wdata = 64'hAAAA; ls_req = 1'b1;
    @(negedge CLK);
    w1 = WRR;
    #2;
    Reset_n = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    #1;
    checks++;
    if (w1 !== 1'b1 || {RCS, RR, WRR, ls_gnt, ls_done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got wrr_before=%b ctrl=%b want 1 000000",
               w1, {RCS, RR, WRR, ls_gnt, ls_done, busy});
    end
    @(negedge CLK);
    Reset_n = 1'b1;
    checks++;
    if (ram[8'h30] !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid_ram: got %h want 0", ram[8'h30]);
    end
    if_addr = 16'h0008; if_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      sample_cycle(c);
      if (c == 3) if_req = 1'b0;
    end
    checks++;
    if (v_id !== 12'h004 || v_rcs !== 12'h003 || if_rdata !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL reset_mid_recover: got done=%h rcs=%h rdata=%h want 004 003 deadbeef",
               v_id, v_rcs, if_rdata);
    end
  endtask

`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  task automatic test_align;
    clear_trace();
    ls_addr = 16'h0013; ls_we = 1'b0; ls_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      sample_cycle(c);
      if (c == 1) ls_req = 1'b0;
    end
    checks++;
    if (v_rcs !== 12'h000 || v_ld !== 12'h001 || v_err !== 12'h001) begin
      errors++;
      $display("FAIL align_err: got rcs=%h done=%h err=%h want 000 001 001", v_rcs, v_ld, v_err);
    end
    checks++;
    if (ls_rdata !== 64'h0) begin
      errors++;
      $display("FAIL align_rdata: got %h want 0", ls_rdata);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h08] = 64'hDEAD_BEEF;
    ram[8'h20] = 64'hCAFE;
    ram[8'h28] = 64'h5555;
    ram[8'h13] = 64'h77;
    test_reset();
    test_fetch();
    test_store();
    test_tie();
    test_drop();
    test_reset_mid();
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    test_align();
`endif
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
